// File: rtl/spi_slv_modport_pkg.sv
// ---------------------------------------------------------------------------
// spi_slv_modport_pkg
// Shared definitions for the SPI-slave-to-bus bridge: frame FSM state
// encoding, slot boundaries of the read/write frames, status byte layout.
// ---------------------------------------------------------------------------
package spi_slv_modport_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_GAP,
    ST_ADDR,
    ST_DATA_IO,
    ST_DUMMY,
    ST_STATUS
  } state_t;

  // Slot numbers count sck rising edges from the ss_n falling edge (first = 1).
  localparam logic [6:0] SLOT_INSTR_END     = 7'd8;
  localparam logic [6:0] SLOT_GAP1          = 7'd9;
  localparam logic [6:0] SLOT_ADDR_END      = 7'd41;
  localparam logic [6:0] SLOT_RD_DATA_FIRST = 7'd49;
  localparam logic [6:0] SLOT_WR_DATA_END   = 7'd73;
  localparam logic [6:0] SLOT_RD_DATA_LAST  = 7'd80;
  localparam logic [6:0] SLOT_GAP2          = 7'd81;
  localparam logic [6:0] SLOT_STATUS_FIRST  = 7'd82;
  localparam logic [6:0] SLOT_STATUS_LAST   = 7'd89;

  // Status byte: [7:4] marker, then flag bits below.
  localparam int unsigned STAT_ACK     = 0;
  localparam int unsigned STAT_ERR     = 1;
  localparam int unsigned STAT_TIMEOUT = 2;
  localparam int unsigned STAT_ILLEGAL = 3;
  localparam logic [3:0]  STATUS_MARKER = 4'hA;

endpackage

// File: rtl/spi_slv_modport_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// STAGES-deep synchronizer for one asynchronous input plus single-clk
// rise/fall pulses derived from the synchronized level.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_async      : asynchronous input
//   o_sync       : synchronized level (RST_VAL while in reset)
//   o_rise/o_fall: one-clk pulses on synchronized edges
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain[0] <= i_async;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slv_modport.sv
// ---------------------------------------------------------------------------
// spi_slv_modport
// SPI mode-0 slave that turns one SPI frame into one 32-bit bus access.
// Read frame : instr 1..8, gap 9, addr 10..41, dummy 42..48,
//              rdata on miso 49..80, gap 81, status on miso 82..89.
// Write frame: instr 1..8, gap 9, addr 10..41, wdata 42..73,
//              dummy 74..81, status on miso 82..89.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sck, ss_n, mosi     : SPI inputs (asynchronous to clk)
//   miso                : SPI data out, always driven
//   bus_req, bus_we     : bus request / write select
//   bus_addr, bus_wdata : bus address / write data (held while bus_req)
//   bus_ack, bus_err    : bus completion / error
//   bus_rdata           : read data, valid with bus_ack
// ---------------------------------------------------------------------------
module spi_slv_modport
  import spi_slv_modport_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  INSTR_WR    = 8'h00,
  parameter logic [7:0]  INSTR_RD    = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  // Cycles after reset before the synchronized ss_n reflects the pin.
  localparam logic [7:0] FLUSH_CYCLES = 8'(SYNC_STAGES + 1);

  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_ss, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(clk), .i_rst(rst), .i_async(sck),
    .o_sync(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(clk), .i_rst(rst), .i_async(ss_n),
    .o_sync(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk), .i_rst(rst), .i_async(mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  state_t      r_state, w_state_next;
  logic [6:0]  r_slot;
  logic [31:0] r_shift;
  logic        r_is_wr, r_illegal, r_timeout, r_err, r_ack;
  logic [31:0] r_rdata, r_addr_cap;
  logic        r_req, r_we, r_discard;
  logic [31:0] r_addr, r_wdata;
  logic        r_miso;
  logic [7:0]  r_flush;
  logic        r_armed;

  logic        w_active, w_frame_start, w_rise, w_fall;
  logic [6:0]  w_slot_next;
  logic [31:0] w_cap, w_rd_word;
  logic        w_bus_done, w_deadline, w_issue;
  logic [7:0]  w_status;
  logic        w_miso_next;
  logic        w_unused;

  assign w_unused = ^{w_sck, w_ss_rise, w_mosi_rise, w_mosi_fall, r_shift[31]};

  assign w_active      = (r_state != ST_IDLE);
  // Only a falling edge seen after ss_n was observed high counts as a frame start.
  assign w_frame_start = w_ss_fall && r_armed;
  // ss_n high wins over any sck edge in the same clk.
  assign w_rise        = w_sck_rise && !w_ss && w_active;
  assign w_fall        = w_sck_fall && !w_ss && w_active;
  assign w_slot_next   = r_slot + 7'd1;
  assign w_cap         = {r_shift[30:0], w_mosi};
  assign w_bus_done    = r_req && (bus_ack || bus_err);
  assign w_deadline    = w_fall && r_req && !r_discard && !w_bus_done &&
                         ((r_is_wr  && (w_slot_next == SLOT_STATUS_FIRST)) ||
                          (!r_is_wr && (w_slot_next == SLOT_RD_DATA_FIRST)));
  assign w_issue       = w_rise && !r_illegal &&
                         ((!r_is_wr && (w_slot_next == SLOT_ADDR_END)) ||
                          (r_is_wr  && (w_slot_next == SLOT_WR_DATA_END)));

  // Forward bus_rdata when the ack lands on the same clk as the first data bit.
  assign w_rd_word = (w_bus_done && !r_discard && !bus_err && !r_we) ? bus_rdata : r_rdata;

  always_comb begin
    w_status               = '0;
    w_status[7:4]          = STATUS_MARKER;
    w_status[STAT_ILLEGAL] = r_illegal;
    w_status[STAT_TIMEOUT] = r_timeout;
    w_status[STAT_ERR]     = r_err;
    w_status[STAT_ACK]     = r_ack;
  end

  always_comb begin
    w_miso_next = 1'b0;
    if (!r_is_wr && (w_slot_next >= SLOT_RD_DATA_FIRST) && (w_slot_next <= SLOT_RD_DATA_LAST)) begin
      w_miso_next = w_rd_word[5'(SLOT_RD_DATA_LAST - w_slot_next)];
    end else if ((w_slot_next >= SLOT_STATUS_FIRST) && (w_slot_next <= SLOT_STATUS_LAST)) begin
      w_miso_next = w_status[3'(SLOT_STATUS_LAST - w_slot_next)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_ss) begin
      w_state_next = ST_IDLE;
    end else if (w_frame_start) begin
      w_state_next = ST_INSTR;
    end else if (w_rise) begin
      unique case (r_state)
        ST_INSTR:   if (w_slot_next == SLOT_INSTR_END) w_state_next = ST_GAP;
        ST_GAP: begin
          if (w_slot_next == SLOT_GAP1)      w_state_next = ST_ADDR;
          else if (w_slot_next == SLOT_GAP2) w_state_next = ST_STATUS;
        end
        ST_ADDR:    if (w_slot_next == SLOT_ADDR_END) w_state_next = r_is_wr ? ST_DATA_IO : ST_DUMMY;
        ST_DATA_IO: begin
          if (r_is_wr && (w_slot_next == SLOT_WR_DATA_END))        w_state_next = ST_DUMMY;
          else if (!r_is_wr && (w_slot_next == SLOT_RD_DATA_LAST)) w_state_next = ST_GAP;
        end
        ST_DUMMY: begin
          if (r_is_wr && (w_slot_next == SLOT_GAP2)) w_state_next = ST_STATUS;
          else if (!r_is_wr && (w_slot_next == SLOT_RD_DATA_FIRST - 7'd1)) w_state_next = ST_DATA_IO;
        end
        ST_STATUS:  if (w_slot_next == SLOT_STATUS_LAST) w_state_next = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= '0;
      r_shift    <= '0;
      r_is_wr    <= 1'b0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_addr_cap <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_discard  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_miso     <= 1'b0;
      r_flush    <= '0;
      r_armed    <= 1'b0;
    end else begin
      if (r_flush != FLUSH_CYCLES) r_flush <= r_flush + 8'd1;
      else if (w_ss)               r_armed <= 1'b1;

      if (w_ss || w_frame_start) begin
        r_slot <= '0;
      end else if (w_rise) begin
        r_slot  <= w_slot_next;
        r_shift <= w_cap;
      end

      if (w_ss || w_frame_start) r_miso <= 1'b0;
      else if (w_sck_fall)       r_miso <= w_active && w_miso_next;

      if (w_frame_start) begin
        r_is_wr   <= 1'b0;
        r_illegal <= 1'b0;
        r_timeout <= 1'b0;
        r_err     <= 1'b0;
        r_ack     <= 1'b0;
        r_rdata   <= '0;
      end

      if (w_rise && (w_slot_next == SLOT_INSTR_END)) begin
        r_is_wr   <= (w_cap[7:0] == INSTR_WR);
        r_illegal <= (w_cap[7:0] != INSTR_WR) && (w_cap[7:0] != INSTR_RD);
      end

      if (w_rise && (w_slot_next == SLOT_ADDR_END)) r_addr_cap <= w_cap;

      if (w_bus_done) begin
        r_req     <= 1'b0;
        r_discard <= 1'b0;
        if (!r_discard) begin
          if (bus_err) begin
            r_err <= 1'b1;
          end else begin
            r_ack <= 1'b1;
            if (!r_we) r_rdata <= bus_rdata;
          end
        end
      end else if (w_deadline) begin
        r_req     <= 1'b0;
        r_timeout <= 1'b1;
      end else if (w_ss && r_req) begin
        // Aborted frame: let the access finish on the bus but drop its result.
        r_discard <= 1'b1;
      end

      if (w_issue) begin
        if (r_req) begin
          // An aborted frame's access is still outstanding; report instead of reissuing.
          r_timeout <= 1'b1;
        end else begin
          r_req <= 1'b1;
          r_we  <= r_is_wr;
          if (r_is_wr) begin
            r_addr  <= r_addr_cap;
            r_wdata <= w_cap;
          end else begin
            r_addr <= w_cap;
          end
        end
      end
    end
  end

  assign miso      = r_miso;
  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_spi_slv_modport.sv
// ---------------------------------------------------------------------------
// tb_spi_slv_modport
// Directed bench: an SPI master task drives complete (or aborted) frames,
// a bus responder answers requests with ack / err / silence.
// ---------------------------------------------------------------------------
module tb_spi_slv_modport;

  localparam int HALF = 80;   // sck half period; clk period is 10

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Responder configuration: 0 = ack, 1 = err, 2 = never answer.
  int          resp_mode  = 0;
  int          resp_delay = 3;
  logic [31:0] resp_data  = '0;

  int          req_cnt  = 0;
  int          unstable = 0;
  int          wait_cnt = 0;
  bit          seen     = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_we   = 1'b0;

  logic [31:0] rd;
  logic [7:0]  st;
  int          bad;
  logic        r48, r49;

  spi_slv_modport #(
    .SYNC_STAGES(2),
    .INSTR_WR(8'h00),
    .INSTR_RD(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 32'h5A5A_A5A5;
    if (rst || !bus_req) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        req_cnt++;
        cap_addr  = bus_addr;
        cap_we    = bus_we;
        cap_wdata = bus_wdata;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
        if (bus_addr !== cap_addr || bus_we !== cap_we || bus_wdata !== cap_wdata) unstable++;
      end
      if (wait_cnt == resp_delay) begin
        if (resp_mode == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = resp_data;
        end else if (resp_mode == 1) begin
          bus_err = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // One SPI frame. miso for slot k is sampled just before rise k.
  task automatic spi_frame(input logic [7:0] instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int nslots,
                           input int abort_at, input bit no_fall,
                           output logic [31:0] o_rd, output logic [7:0] o_st,
                           output int o_bad, output logic o_r48, output logic o_r49);
    o_rd = '0; o_st = '0; o_bad = 0; o_r48 = 1'b0; o_r49 = 1'b0;
    @(negedge clk); #2;
    sck = 1'b0;
    if (!no_fall) ss_n = 1'b0;
    #(HALF);
    for (int k = 1; k <= nslots; k++) begin
      if (k <= 8)                 mosi = instr[8-k];
      else if (k >= 10 && k <= 41) mosi = addr[41-k];
      else if (k >= 42 && k <= 73) mosi = wdata[73-k];
      else                        mosi = 1'b0;
      #(HALF);
      if (k >= 49 && k <= 80)      o_rd[80-k] = miso;
      else if (k >= 82 && k <= 89) o_st[89-k] = miso;
      else if (miso !== 1'b0)      o_bad++;
      if (k == 48) o_r48 = bus_req;
      if (k == 49) o_r49 = bus_req;
      sck = 1'b1;
      #(HALF);
      if (k == abort_at) begin
        ss_n = 1'b1;
        sck  = 1'b0;
        break;
      end
      sck = 1'b0;
    end
    sck  = 1'b0;
    mosi = 1'b0;
    #(HALF);
    ss_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (miso !== 1'b0)      begin errors++; $display("FAIL rst_miso got %b exp 0", miso); end
    checks++; if (bus_req !== 1'b0)   begin errors++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0)    begin errors++; $display("FAIL rst_bus_we got %b exp 0", bus_we); end
    checks++; if (bus_addr !== '0)    begin errors++; $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
    checks++; if (bus_wdata !== '0)   begin errors++; $display("FAIL rst_bus_wdata got %h exp 0", bus_wdata); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (miso !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL post_rst_idle got miso=%b req=%b exp 0/0", miso, bus_req); end
  endtask

  task automatic test_read();
    int n0;
    n0 = req_cnt; resp_mode = 0; resp_delay = 3; resp_data = 32'hDEAD_BEEF;
    spi_frame(8'h01, 32'h1234_5678, 32'h0, 95, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0 + 1)          begin errors++; $display("FAIL rd_req_count got %0d exp %0d", req_cnt - n0, 1); end
    checks++; if (cap_addr !== 32'h1234_5678)  begin errors++; $display("FAIL rd_bus_addr got %h exp 12345678", cap_addr); end
    checks++; if (cap_we !== 1'b0)             begin errors++; $display("FAIL rd_bus_we got %b exp 0", cap_we); end
    checks++; if (rd !== 32'hDEAD_BEEF)        begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    checks++; if (st !== 8'hA1)                begin errors++; $display("FAIL rd_status got %h exp a1", st); end
    checks++; if (bad !== 0)                   begin errors++; $display("FAIL rd_idle_miso got %0d nonzero exp 0", bad); end
  endtask

  task automatic test_write();
    int n0;
    n0 = req_cnt; resp_mode = 0; resp_delay = 2; resp_data = 32'h1111_2222;
    spi_frame(8'h00, 32'h0000_0010, 32'hCAFE_F00D, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0 + 1)          begin errors++; $display("FAIL wr_req_count got %0d exp %0d", req_cnt - n0, 1); end
    checks++; if (cap_we !== 1'b1)             begin errors++; $display("FAIL wr_bus_we got %b exp 1", cap_we); end
    checks++; if (cap_addr !== 32'h0000_0010)  begin errors++; $display("FAIL wr_bus_addr got %h exp 00000010", cap_addr); end
    checks++; if (cap_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_bus_wdata got %h exp cafef00d", cap_wdata); end
    checks++; if (st !== 8'hA1)                begin errors++; $display("FAIL wr_status got %h exp a1", st); end
    checks++; if (rd !== 32'h0 || bad !== 0)   begin errors++; $display("FAIL wr_miso_quiet got rd=%h bad=%0d exp 0/0", rd, bad); end
  endtask

  task automatic test_timeout();
    int n0;
    n0 = req_cnt; resp_mode = 2;
    spi_frame(8'h01, 32'hA5A5_0000, 32'h0, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0 + 1)  begin errors++; $display("FAIL to_req_count got %0d exp 1", req_cnt - n0); end
    checks++; if (r48 !== 1'b1)        begin errors++; $display("FAIL to_req_before_deadline got %b exp 1", r48); end
    checks++; if (r49 !== 1'b0)        begin errors++; $display("FAIL to_req_after_deadline got %b exp 0", r49); end
    checks++; if (rd !== 32'h0)        begin errors++; $display("FAIL to_data got %h exp 0", rd); end
    checks++; if (st !== 8'hA4)        begin errors++; $display("FAIL to_status got %h exp a4", st); end
    checks++; if (bus_req !== 1'b0)    begin errors++; $display("FAIL to_req_idle got %b exp 0", bus_req); end
  endtask

  task automatic test_bus_err();
    resp_mode = 1; resp_delay = 2;
    spi_frame(8'h01, 32'h0000_0040, 32'h0, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL err_data got %h exp 0", rd); end
    checks++; if (st !== 8'hA2)  begin errors++; $display("FAIL err_status got %h exp a2", st); end
  endtask

  task automatic test_illegal();
    int n0;
    n0 = req_cnt; resp_mode = 0; resp_delay = 1; resp_data = 32'hFFFF_FFFF;
    spi_frame(8'h55, 32'h1234_5678, 32'h0, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0)  begin errors++; $display("FAIL ill_no_req got %0d reqs exp 0", req_cnt - n0); end
    checks++; if (st !== 8'hA8)    begin errors++; $display("FAIL ill_status got %h exp a8", st); end
    checks++; if (rd !== 32'h0)    begin errors++; $display("FAIL ill_data got %h exp 0", rd); end
  endtask

  task automatic test_abort();
    int n0;
    n0 = req_cnt; resp_mode = 0; resp_delay = 3; resp_data = 32'h1357_9BDF;
    spi_frame(8'h01, 32'hFFFF_0000, 32'h0, 89, 20, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0 || bus_req !== 1'b0) begin errors++; $display("FAIL abort_no_req got %0d reqs req=%b exp 0/0", req_cnt - n0, bus_req); end
    checks++; if (miso !== 1'b0)                      begin errors++; $display("FAIL abort_miso got %b exp 0", miso); end
    spi_frame(8'h01, 32'h8765_4321, 32'h0, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0 + 1)          begin errors++; $display("FAIL abort_next_req got %0d exp 1", req_cnt - n0); end
    checks++; if (cap_addr !== 32'h8765_4321)  begin errors++; $display("FAIL abort_next_addr got %h exp 87654321", cap_addr); end
    checks++; if (rd !== 32'h1357_9BDF)        begin errors++; $display("FAIL abort_next_data got %h exp 13579bdf", rd); end
    checks++; if (st !== 8'hA1)                begin errors++; $display("FAIL abort_next_status got %h exp a1", st); end
  endtask

  task automatic test_no_fresh_edge();
    int n0;
    n0 = req_cnt; resp_mode = 0; resp_delay = 2; resp_data = 32'h0F0F_0F0F;
    ss_n = 1'b0; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    spi_frame(8'h01, 32'h0000_0004, 32'h0, 89, 0, 1'b1, rd, st, bad, r48, r49);
    checks++; if (req_cnt !== n0)            begin errors++; $display("FAIL nofresh_no_req got %0d reqs exp 0", req_cnt - n0); end
    checks++; if (st !== 8'h00 || rd !== 0 || bad !== 0) begin errors++; $display("FAIL nofresh_miso got st=%h rd=%h bad=%0d exp 0", st, rd, bad); end
    spi_frame(8'h01, 32'h0000_0004, 32'h0, 89, 0, 1'b0, rd, st, bad, r48, r49);
    checks++; if (rd !== 32'h0F0F_0F0F || st !== 8'hA1) begin errors++; $display("FAIL nofresh_recover got rd=%h st=%h exp 0f0f0f0f/a1", rd, st); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_bus_err();
    test_illegal();
    test_abort();
    test_no_fresh_edge();
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bus_hold_stable got %0d changes exp 0", unstable); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
